// File: rtl/day9_rect_area_engine_if.sv
// Point-stream handshake for the rectangle area engine.
// The producer (master) offers one (x, y) point per cycle; last marks the final point of a set.
interface day9_rect_area_engine_if #(
    parameter int W = 17
);
    logic         valid;
    logic         ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         last;

    modport master (output valid, output x, output y, output last, input ready);
    modport slave  (input valid, input x, input y, input last, output ready);
endinterface

// File: rtl/day9_rect_area_engine.sv
// Streaming max-rectangle engine.
// Each accepted point is paired with every point already stored. Each pair forms the opposite
// corners of a rectangle. The engine keeps the largest area and the indices of the pair that
// produced it.
// The compare path is a free-running 4-stage pipeline: read, |d|, product, compare.
module day9_rect_area_engine #(
    parameter int W          = 17,
    parameter int DEPTH      = 512,
    parameter bit INCLUSIVE  = 1'b1,
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clear,
    day9_rect_area_engine_if.slave        s_in,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [2*W+1:0]                o_area_max,
    output logic [IW-1:0]                 o_best_a,
    output logic [IW-1:0]                 o_best_b,
    output logic [IW:0]                   o_count,
    output logic                          o_overflow
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic [IW:0] L_FULL = (IW+1)'(DEPTH);
    localparam logic [W:0]  L_INC  = {{W{1'b0}}, INCLUSIVE};

    state_t          r_state;
    state_t          w_state_next;
    logic            r_ready;
    logic [IW:0]     r_count;
    logic [IW-1:0]   r_k;
    logic [IW-1:0]   r_j;
    logic [2*W-1:0]  r_new_pt;
    logic [IW-1:0]   r_new_idx;
    logic            r_last_flag;
    logic [1:0]      r_drain;
    logic            r_done;
    logic            r_overflow;

    logic            w_ready;
    logic            w_accept;
    logic            w_full;
    logic            w_wr_en;
    logic            w_issue;
    logic            w_scan_end;
    logic            w_drain_end;
    logic            w_done_next;

    // Point store: unreset, only r_count marks valid entries.
    logic [2*W-1:0]  mem [DEPTH];
    logic [2*W-1:0]  r_rd_data;

    // Pipeline sideband
    logic            r_s1_vld, r_s2_vld, r_s3_vld;
    logic [IW-1:0]   r_s1_a, r_s2_a, r_s3_a;
    logic [IW-1:0]   r_s1_b, r_s2_b, r_s3_b;
    logic [2*W-1:0]  r_s1_pt;
    logic [2*W+1:0]  r_s3_prod;
    logic [2*W+1:0]  w_prod;

    logic [2*W+1:0]  r_area_max;
    logic [IW-1:0]   r_best_a;
    logic [IW-1:0]   r_best_b;

    // Ready is masked by clear so a point offered in a clear cycle is never seen as taken.
    assign w_ready     = r_ready & ~i_clear;
    assign s_in.ready  = w_ready;
    assign w_accept    = s_in.valid & w_ready;
    assign w_full      = (r_count == L_FULL);
    assign w_wr_en     = w_accept & ~w_full;
    assign w_scan_end  = (r_j == (r_k - 1'b1));
    assign w_drain_end = (r_drain == 2'd3);

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (w_accept) begin
                    if (w_full || (r_count == '0)) begin
                        if (s_in.last) begin
                            w_state_next = ST_DRAIN;
                        end
                    end else begin
                        w_state_next = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                w_issue = 1'b1;
                if (w_scan_end) begin
                    w_state_next = r_last_flag ? ST_DRAIN : ST_ACCEPT;
                end
            end
            ST_DRAIN: begin
                if (w_drain_end) begin
                    w_state_next = ST_ACCEPT;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ACCEPT;
            end
        endcase
    end

    // FSM state, store bookkeeping and scan counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_ACCEPT;
            r_ready     <= 1'b0;
            r_count     <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_new_pt    <= '0;
            r_new_idx   <= '0;
            r_last_flag <= 1'b0;
            r_drain     <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (i_clear) begin
            r_state     <= ST_ACCEPT;
            r_ready     <= 1'b1;
            r_count     <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_new_pt    <= '0;
            r_new_idx   <= '0;
            r_last_flag <= 1'b0;
            r_drain     <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == ST_ACCEPT);
            r_done  <= w_done_next;
            if (w_wr_en) begin
                r_count     <= r_count + 1'b1;
                r_new_pt    <= {s_in.x, s_in.y};
                r_new_idx   <= r_count[IW-1:0];
                r_k         <= r_count[IW-1:0];
                r_j         <= '0;
                r_last_flag <= s_in.last;
            end else if (r_state == ST_SCAN) begin
                r_j <= r_j + 1'b1;
            end
            if (w_accept && w_full) begin
                r_overflow <= 1'b1;
            end
            r_drain <= (r_state == ST_DRAIN) ? r_drain + 1'b1 : 2'd0;
        end
    end

    // Point store write and registered read (stage 1 data).
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            mem[r_count[IW-1:0]] <= {s_in.x, s_in.y};
        end
        r_rd_data <= mem[r_j];
    end

    // Stage 2: per-axis absolute distance, widened by one bit so the +1 never wraps.
    // Axis 0 is x (upper half of a stored point), axis 1 is y.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dim
            logic [W-1:0] w_old_c;
            logic [W-1:0] w_new_c;
            logic [W-1:0] w_abs;
            logic [W:0]   r_s2_d;

            assign w_old_c = r_rd_data[(2-gi)*W-1 -: W];
            assign w_new_c = r_s1_pt[(2-gi)*W-1 -: W];
            assign w_abs   = (w_old_c >= w_new_c) ? (w_old_c - w_new_c) : (w_new_c - w_old_c);

            // Register the side length for this axis.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_s2_d <= '0;
                end else if (i_clear) begin
                    r_s2_d <= '0;
                end else begin
                    r_s2_d <= {1'b0, w_abs} + L_INC;
                end
            end
        end
    endgenerate

    assign w_prod = {{(W+1){1'b0}}, g_dim[0].r_s2_d} * {{(W+1){1'b0}}, g_dim[1].r_s2_d};

    // Pipeline sideband, product stage and best-pair update; clear flushes in-flight pairs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s3_vld   <= 1'b0;
            r_s1_a     <= '0;
            r_s2_a     <= '0;
            r_s3_a     <= '0;
            r_s1_b     <= '0;
            r_s2_b     <= '0;
            r_s3_b     <= '0;
            r_s1_pt    <= '0;
            r_s3_prod  <= '0;
            r_area_max <= '0;
            r_best_a   <= '0;
            r_best_b   <= '0;
        end else if (i_clear) begin
            r_s1_vld   <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s3_vld   <= 1'b0;
            r_s1_a     <= '0;
            r_s2_a     <= '0;
            r_s3_a     <= '0;
            r_s1_b     <= '0;
            r_s2_b     <= '0;
            r_s3_b     <= '0;
            r_s1_pt    <= '0;
            r_s3_prod  <= '0;
            r_area_max <= '0;
            r_best_a   <= '0;
            r_best_b   <= '0;
        end else begin
            r_s1_vld  <= w_issue;
            r_s1_a    <= r_j;
            r_s1_b    <= r_new_idx;
            r_s1_pt   <= r_new_pt;
            r_s2_vld  <= r_s1_vld;
            r_s2_a    <= r_s1_a;
            r_s2_b    <= r_s1_b;
            r_s3_vld  <= r_s2_vld;
            r_s3_a    <= r_s2_a;
            r_s3_b    <= r_s2_b;
            r_s3_prod <= w_prod;
            // Strictly greater only: pairs arrive in (b, a) order, so ties keep the earliest.
            if (r_s3_vld && (r_s3_prod > r_area_max)) begin
                r_area_max <= r_s3_prod;
                r_best_a   <= r_s3_a;
                r_best_b   <= r_s3_b;
            end
        end
    end

    assign o_busy     = (r_state != ST_ACCEPT);
    assign o_done     = r_done;
    assign o_area_max = r_area_max;
    assign o_best_a   = r_best_a;
    assign o_best_b   = r_best_b;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_day9_rect_area_engine.sv
// Directed bench for the rectangle area engine: three instances (inclusive, exclusive,
// 4-deep store) driven from one shared stimulus path selected by sel.
module tb_day9_rect_area_engine;
    localparam int W = 17;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         drv_clear = 1'b0;
    logic         drv_valid = 1'b0;
    logic         drv_last = 1'b0;
    logic [W-1:0] drv_x = '0;
    logic [W-1:0] drv_y = '0;
    int           sel = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    day9_rect_area_engine_if #(.W(W)) if0 ();
    day9_rect_area_engine_if #(.W(W)) if1 ();
    day9_rect_area_engine_if #(.W(W)) if2 ();

    assign if0.valid = drv_valid && (sel == 0);
    assign if1.valid = drv_valid && (sel == 1);
    assign if2.valid = drv_valid && (sel == 2);
    assign if0.x = drv_x;  assign if1.x = drv_x;  assign if2.x = drv_x;
    assign if0.y = drv_y;  assign if1.y = drv_y;  assign if2.y = drv_y;
    assign if0.last = drv_last;  assign if1.last = drv_last;  assign if2.last = drv_last;

    logic         busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
    logic [2*W+1:0] area0, area1, area2;
    logic [8:0]   a0, b0, a1, b1;
    logic [9:0]   cnt0, cnt1;
    logic [1:0]   a2, b2;
    logic [2:0]   cnt2;

    day9_rect_area_engine #(.W(W), .DEPTH(512), .INCLUSIVE(1'b1)) u_inc (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(drv_clear), .s_in(if0),
        .o_busy(busy0), .o_done(done0), .o_area_max(area0), .o_best_a(a0), .o_best_b(b0),
        .o_count(cnt0), .o_overflow(ovf0));

    day9_rect_area_engine #(.W(W), .DEPTH(512), .INCLUSIVE(1'b0)) u_exc (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(drv_clear), .s_in(if1),
        .o_busy(busy1), .o_done(done1), .o_area_max(area1), .o_best_a(a1), .o_best_b(b1),
        .o_count(cnt1), .o_overflow(ovf1));

    day9_rect_area_engine #(.W(W), .DEPTH(4), .INCLUSIVE(1'b1)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(drv_clear), .s_in(if2),
        .o_busy(busy2), .o_done(done2), .o_area_max(area2), .o_best_a(a2), .o_best_b(b2),
        .o_count(cnt2), .o_overflow(ovf2));

    // View of the selected instance.
    logic        cur_ready, cur_busy, cur_done, cur_ovf;
    logic [63:0] cur_area, cur_a, cur_b, cur_cnt;
    always_comb begin
        cur_ready = if0.ready; cur_busy = busy0; cur_done = done0; cur_ovf = ovf0;
        cur_area = 64'(area0); cur_a = 64'(a0); cur_b = 64'(b0); cur_cnt = 64'(cnt0);
        case (sel)
            1: begin
                cur_ready = if1.ready; cur_busy = busy1; cur_done = done1; cur_ovf = ovf1;
                cur_area = 64'(area1); cur_a = 64'(a1); cur_b = 64'(b1); cur_cnt = 64'(cnt1);
            end
            2: begin
                cur_ready = if2.ready; cur_busy = busy2; cur_done = done2; cur_ovf = ovf2;
                cur_area = 64'(area2); cur_a = 64'(a2); cur_b = 64'(b2); cur_cnt = 64'(cnt2);
            end
            default: ;
        endcase
    end

    typedef struct {
        int sel;        // instance
        int clr;        // pulse clear before this point
        int x;
        int y;
        int last;
        int exp_wait;   // cycles from accept+1 to ready (or to done if last)
        int exp_count;
        int exp_area;   // final results, checked at done only
        int exp_a;
        int exp_b;
        int exp_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        sel = v.sel;
        if (v.clr != 0) begin
            drv_clear = 1'b1;
            tick();
            drv_clear = 1'b0;
        end
        n = 0;
        while (!cur_ready && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("v%0d_ready_before", idx), 64'(cur_ready), 64'd1);
        drv_valid = 1'b1;
        drv_x = W'(v.x);
        drv_y = W'(v.y);
        drv_last = (v.last != 0);
        tick();
        drv_valid = 1'b0;
        drv_last = 1'b0;
        check($sformatf("v%0d_count", idx), cur_cnt, 64'(v.exp_count));
        check($sformatf("v%0d_busy", idx), 64'(cur_busy), 64'(v.exp_wait > 0));
        n = 0;
        if (v.last == 0) begin
            while (!cur_ready && n < 2000) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_wait", idx), 64'(n), 64'(v.exp_wait));
        end else begin
            while (!cur_done && n < 2000) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_done_lat", idx), 64'(n), 64'(v.exp_wait));
            check($sformatf("v%0d_area", idx), cur_area, 64'(v.exp_area));
            check($sformatf("v%0d_best_a", idx), cur_a, 64'(v.exp_a));
            check($sformatf("v%0d_best_b", idx), cur_b, 64'(v.exp_b));
            check($sformatf("v%0d_ovf", idx), 64'(cur_ovf), 64'(v.exp_ovf));
            tick();
            check($sformatf("v%0d_done_pulse", idx), 64'(cur_done), 64'd0);
        end
        $display("vec %0d: inst=%0d pt=(%0d,%0d) last=%0d cycles=%0d count=%0d area=%0d",
                 idx, v.sel, v.x, v.y, v.last, n, cur_cnt, cur_area);
    endtask

    initial begin
        int n;
        int ndone;
        //              sel clr  x    y  last wait cnt area a b ovf
        // Set A: inclusive, small triple
        tbl.push_back('{0, 1,   1,   1, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0,   4,   5, 0, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{0, 0,   2,   2, 1, 6, 3, 20, 0, 1, 0});
        // Set B: exclusive, same points
        tbl.push_back('{1, 1,   1,   1, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 0,   4,   5, 0, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{1, 0,   2,   2, 1, 6, 3, 12, 0, 1, 0});
        // Set C: sample input, tie at 50 for pair (2,5) must not displace (1,4)
        tbl.push_back('{0, 1,   7,   1, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0,  11,   1, 0, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{0, 0,  11,   7, 0, 2, 3, 0, 0, 0, 0});
        tbl.push_back('{0, 0,   9,   7, 0, 3, 4, 0, 0, 0, 0});
        tbl.push_back('{0, 0,   2,   5, 0, 4, 5, 0, 0, 0, 0});
        tbl.push_back('{0, 0,   2,   3, 0, 5, 6, 0, 0, 0, 0});
        tbl.push_back('{0, 0,   7,   3, 0, 6, 7, 0, 0, 0, 0});
        tbl.push_back('{0, 0,   9,   5, 1, 11, 8, 50, 1, 4, 0});
        // Set D: single point with last
        tbl.push_back('{0, 1,   7,   7, 1, 4, 1, 0, 0, 0, 0});
        // Set E: 4-deep store, two dropped points (would give larger areas)
        tbl.push_back('{2, 1,   0,   0, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{2, 0,   3,   0, 0, 1, 2, 0, 0, 0, 0});
        tbl.push_back('{2, 0,   0,   2, 0, 2, 3, 0, 0, 0, 0});
        tbl.push_back('{2, 0,  10,  10, 0, 3, 4, 0, 0, 0, 0});
        tbl.push_back('{2, 0, 100, 100, 0, 0, 4, 0, 0, 0, 0});
        tbl.push_back('{2, 0,  50,  50, 1, 4, 4, 121, 0, 3, 1});

        // Reset state
        sel = 0;
        tick();
        tick();
        check("rst_ready", 64'(if0.ready), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_area", 64'(area0), 64'd0);
        check("rst_count", 64'(cnt0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready_after", 64'(if0.ready), 64'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(i, tbl[i]);
        end

        // Async reset in the middle of the scan for the fifth point.
        for (int i = 6; i < 10; i++) begin
            run_vec(i, tbl[i]);
        end
        sel = 0;
        n = 0;
        while (!cur_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("mid_area_before_rst", cur_area, 64'd35);
        drv_valid = 1'b1;
        drv_x = W'(2);
        drv_y = W'(5);
        tick();
        drv_valid = 1'b0;
        check("mid_busy_scan", 64'(cur_busy), 64'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(cur_ready), 64'd0);
        check("mid_rst_busy", 64'(cur_busy), 64'd0);
        check("mid_rst_area", cur_area, 64'd0);
        check("mid_rst_count", cur_cnt, 64'd0);
        check("mid_rst_best_b", cur_b, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (cur_done) ndone++;
        end
        check("mid_rst_no_done", 64'(ndone), 64'd0);
        check("mid_rst_ready_after", 64'(cur_ready), 64'd1);
        $display("mid-scan reset: done pulses after reset=%0d", ndone);
        for (int i = 0; i < 3; i++) begin
            run_vec(100 + i, tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
